// File: rtl/mac_rd_arbiter_if.sv
// Signal bundle between the two read masters, the arbiter and the MAC read channel.
// The arbiter connects through the slave modport; the driving environment uses master.
interface mac_rd_arbiter_if;
    logic        iP0_ValidRd;
    logic [31:0] iP0_AddrRd;
    logic [2:0]  iP0_IdRd;
    logic [1:0]  iP0_LenRd;
    logic [3:0]  iP0_QoSRd;
    logic        oP0_ReadyRd;
    logic        oP0_ValidRsp;
    logic [2:0]  oP0_IdRsp;
    logic [31:0] oP0_DataRsp;
    logic [1:0]  oP0_StatusRsp;
    logic        oP0_EoD;
    logic        iP0_ReadyRsp;

    logic        iP1_ValidRd;
    logic [31:0] iP1_AddrRd;
    logic [2:0]  iP1_IdRd;
    logic [1:0]  iP1_LenRd;
    logic [3:0]  iP1_QoSRd;
    logic        oP1_ReadyRd;
    logic        oP1_ValidRsp;
    logic [2:0]  oP1_IdRsp;
    logic [31:0] oP1_DataRsp;
    logic [1:0]  oP1_StatusRsp;
    logic        oP1_EoD;
    logic        iP1_ReadyRsp;

    logic        oMAC_ValidRd;
    logic [31:0] oMAC_AddrRd;
    logic [3:0]  oMAC_TagRd;
    logic [2:0]  oMAC_IdRd;
    logic [1:0]  oMAC_LenRd;
    logic [3:0]  oMAC_QoSRd;
    logic        iMAC_ReadyRd;
    logic        iMAC_ValidRsp;
    logic [3:0]  iMAC_TagRsp;
    logic [31:0] iMAC_DataRsp;
    logic [1:0]  iMAC_StatusRsp;
    logic        iMAC_EoD;
    logic        oMAC_ReadyRsp;
    logic        oErrUnexp;

    modport slave (
        input  iP0_ValidRd, iP0_AddrRd, iP0_IdRd, iP0_LenRd, iP0_QoSRd, iP0_ReadyRsp,
        input  iP1_ValidRd, iP1_AddrRd, iP1_IdRd, iP1_LenRd, iP1_QoSRd, iP1_ReadyRsp,
        input  iMAC_ReadyRd, iMAC_ValidRsp, iMAC_TagRsp, iMAC_DataRsp, iMAC_StatusRsp,
        input  iMAC_EoD,
        output oP0_ReadyRd, oP0_ValidRsp, oP0_IdRsp, oP0_DataRsp, oP0_StatusRsp, oP0_EoD,
        output oP1_ReadyRd, oP1_ValidRsp, oP1_IdRsp, oP1_DataRsp, oP1_StatusRsp, oP1_EoD,
        output oMAC_ValidRd, oMAC_AddrRd, oMAC_TagRd, oMAC_IdRd, oMAC_LenRd, oMAC_QoSRd,
        output oMAC_ReadyRsp, oErrUnexp
    );

    modport master (
        output iP0_ValidRd, iP0_AddrRd, iP0_IdRd, iP0_LenRd, iP0_QoSRd, iP0_ReadyRsp,
        output iP1_ValidRd, iP1_AddrRd, iP1_IdRd, iP1_LenRd, iP1_QoSRd, iP1_ReadyRsp,
        output iMAC_ReadyRd, iMAC_ValidRsp, iMAC_TagRsp, iMAC_DataRsp, iMAC_StatusRsp,
        output iMAC_EoD,
        input  oP0_ReadyRd, oP0_ValidRsp, oP0_IdRsp, oP0_DataRsp, oP0_StatusRsp, oP0_EoD,
        input  oP1_ReadyRd, oP1_ValidRsp, oP1_IdRsp, oP1_DataRsp, oP1_StatusRsp, oP1_EoD,
        input  oMAC_ValidRd, oMAC_AddrRd, oMAC_TagRd, oMAC_IdRd, oMAC_LenRd, oMAC_QoSRd,
        input  oMAC_ReadyRsp, oErrUnexp
    );
endinterface

// File: rtl/mac_rd_arbiter.sv
// Two-port read-request arbiter in front of the MAC read channel: QoS priority with
// round-robin tie-break and age-based anti-starvation; responses routed back by tag MSB.
module mac_rd_arbiter #(
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned AGE_LIMIT = 15
) (
    input logic             clk,
    input logic             reset,
    mac_rd_arbiter_if.slave bus
);
    localparam logic [3:0] MaxOutst = 4'(MAX_OUTST);
    localparam logic [3:0] AgeLimit = 4'(AGE_LIMIT);

    logic [1:0]  reqValid;
    logic [31:0] reqAddr [2];
    logic [2:0]  reqId   [2];
    logic [1:0]  reqLen  [2];
    logic [3:0]  reqQoS  [2];

    logic        slotValidQ;
    logic [31:0] slotAddrQ;
    logic [3:0]  slotTagQ;
    logic [2:0]  slotIdQ;
    logic [1:0]  slotLenQ;
    logic [3:0]  slotQoSQ;
    logic [3:0]  outstQ [2];
    logic [3:0]  outstD [2];
    logic [3:0]  ageQ   [2];
    logic [3:0]  ageD   [2];
    logic        rrQ, rrD;
    logic        errQ;

    logic [1:0]  eligible, grant, accept, eodDone;
    logic        loadable, winner, aged0, aged1;
    logic        rspSel, rspReady, rspEod, unexp;

    assign reqValid   = {bus.iP1_ValidRd, bus.iP0_ValidRd};
    assign reqAddr[0] = bus.iP0_AddrRd;
    assign reqAddr[1] = bus.iP1_AddrRd;
    assign reqId[0]   = bus.iP0_IdRd;
    assign reqId[1]   = bus.iP1_IdRd;
    assign reqLen[0]  = bus.iP0_LenRd;
    assign reqLen[1]  = bus.iP1_LenRd;
    assign reqQoS[0]  = bus.iP0_QoSRd;
    assign reqQoS[1]  = bus.iP1_QoSRd;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            eligible[p] = reqValid[p] && (outstQ[p] < MaxOutst);
        end
    end

    // The slot can take a new request while its current one is leaving.
    assign loadable = !slotValidQ || bus.iMAC_ReadyRd;

    always_comb begin
        grant = 2'b00;
        aged0 = (ageQ[0] == AgeLimit);
        aged1 = (ageQ[1] == AgeLimit);
        if (eligible == 2'b01) begin
            grant = 2'b01;
        end else if (eligible == 2'b10) begin
            grant = 2'b10;
        end else if (eligible == 2'b11) begin
            if (aged0 != aged1) begin
                grant = aged0 ? 2'b01 : 2'b10;
            end else if (reqQoS[0] > reqQoS[1]) begin
                grant = 2'b01;
            end else if (reqQoS[1] > reqQoS[0]) begin
                grant = 2'b10;
            end else begin
                // rrQ holds the last winner; the other port takes the tie.
                grant = rrQ ? 2'b01 : 2'b10;
            end
        end
    end

    assign accept = (loadable && !reset) ? grant : 2'b00;
    assign winner = accept[1];

    assign rspSel   = bus.iMAC_TagRsp[3];
    assign rspReady = rspSel ? bus.iP1_ReadyRsp : bus.iP0_ReadyRsp;
    assign rspEod   = bus.iMAC_ValidRsp && rspReady && bus.iMAC_EoD;
    assign unexp    = rspEod && (outstQ[rspSel] == 4'd0);

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            eodDone[p] = rspEod && (rspSel == 1'(p)) && (outstQ[p] != 4'd0);
        end
    end

    always_comb begin
        rrD = rrQ;
        for (int p = 0; p < 2; p++) begin
            outstD[p] = outstQ[p];
            ageD[p]   = ageQ[p];
            if (accept[p] && !eodDone[p]) begin
                outstD[p] = outstQ[p] + 4'd1;
            end else if (!accept[p] && eodDone[p]) begin
                outstD[p] = outstQ[p] - 4'd1;
            end
        end
        if (accept != 2'b00) begin
            rrD = winner;
            for (int p = 0; p < 2; p++) begin
                if (accept[p]) begin
                    ageD[p] = 4'd0;
                end else if (eligible[p] && (ageQ[p] < AgeLimit)) begin
                    ageD[p] = ageQ[p] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slotValidQ <= 1'b0;
            slotAddrQ  <= '0;
            slotTagQ   <= '0;
            slotIdQ    <= '0;
            slotLenQ   <= '0;
            slotQoSQ   <= '0;
            outstQ     <= '{default: '0};
            ageQ       <= '{default: '0};
            rrQ        <= 1'b1;
            errQ       <= 1'b0;
        end else begin
            outstQ <= outstD;
            ageQ   <= ageD;
            rrQ    <= rrD;
            if (loadable) begin
                slotValidQ <= |accept;
                if (|accept) begin
                    slotAddrQ <= reqAddr[winner];
                    slotTagQ  <= {winner, reqId[winner]};
                    slotIdQ   <= reqId[winner];
                    slotLenQ  <= reqLen[winner];
                    slotQoSQ  <= reqQoS[winner];
                end
            end
            if (unexp) begin
                errQ <= 1'b1;
            end
        end
    end

    assign bus.oP0_ReadyRd  = accept[0];
    assign bus.oP1_ReadyRd  = accept[1];
    assign bus.oMAC_ValidRd = slotValidQ;
    assign bus.oMAC_AddrRd  = slotAddrQ;
    assign bus.oMAC_TagRd   = slotTagQ;
    assign bus.oMAC_IdRd    = slotIdQ;
    assign bus.oMAC_LenRd   = slotLenQ;
    assign bus.oMAC_QoSRd   = slotQoSQ;
    assign bus.oErrUnexp    = errQ;

    assign bus.oMAC_ReadyRsp = rspReady;
    assign bus.oP0_ValidRsp  = bus.iMAC_ValidRsp && !rspSel;
    assign bus.oP1_ValidRsp  = bus.iMAC_ValidRsp && rspSel;
    assign bus.oP0_IdRsp     = bus.iMAC_TagRsp[2:0];
    assign bus.oP1_IdRsp     = bus.iMAC_TagRsp[2:0];
    assign bus.oP0_DataRsp   = bus.iMAC_DataRsp;
    assign bus.oP1_DataRsp   = bus.iMAC_DataRsp;
    assign bus.oP0_StatusRsp = bus.iMAC_StatusRsp;
    assign bus.oP1_StatusRsp = bus.iMAC_StatusRsp;
    assign bus.oP0_EoD       = bus.iMAC_EoD;
    assign bus.oP1_EoD       = bus.iMAC_EoD;
endmodule

// File: tb/tb_mac_rd_arbiter.sv
// Directed bench for mac_rd_arbiter (MAX_OUTST = 4, AGE_LIMIT = 3).
module tb_mac_rd_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mac_rd_arbiter_if bus();

    mac_rd_arbiter #(
        .MAX_OUTST(4),
        .AGE_LIMIT(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.iP0_ValidRd = 0; bus.iP0_AddrRd = '0; bus.iP0_IdRd = '0; bus.iP0_LenRd = '0;
        bus.iP0_QoSRd = '0; bus.iP0_ReadyRsp = 0;
        bus.iP1_ValidRd = 0; bus.iP1_AddrRd = '0; bus.iP1_IdRd = '0; bus.iP1_LenRd = '0;
        bus.iP1_QoSRd = '0; bus.iP1_ReadyRsp = 0;
        bus.iMAC_ReadyRd = 0; bus.iMAC_ValidRsp = 0; bus.iMAC_TagRsp = '0;
        bus.iMAC_DataRsp = '0; bus.iMAC_StatusRsp = '0; bus.iMAC_EoD = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        bus.iP0_ValidRd = 1;
        bus.iMAC_ReadyRd = 1;
        bus.iMAC_ValidRsp = 1; bus.iMAC_TagRsp = 4'b1010; bus.iP1_ReadyRsp = 1;
        #1;
        vectors++;
        if (bus.oP0_ReadyRd !== 1'b0) begin
            miscompares++; $display("FAIL reset_ready0: got %b want 0", bus.oP0_ReadyRd);
        end
        vectors++;
        if (bus.oMAC_ReadyRsp !== 1'b1 || bus.oP1_ValidRsp !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_rsp_comb: got rdy %b v1 %b want 1 1",
                     bus.oMAC_ReadyRsp, bus.oP1_ValidRsp);
        end
        tick();
        vectors++;
        if (bus.oMAC_ValidRd !== 1'b0 || bus.oMAC_TagRd !== 4'h0 || bus.oErrUnexp !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got v %b tag %h err %b want 0 0 0",
                     bus.oMAC_ValidRd, bus.oMAC_TagRd, bus.oErrUnexp);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        bus.iMAC_ReadyRd = 1;
        bus.iP0_ValidRd = 1; bus.iP0_AddrRd = 32'h2325_F220; bus.iP0_IdRd = 3'b101;
        bus.iP0_LenRd = 2'b10; bus.iP0_QoSRd = 4'b0110;
        #1;
        vectors++;
        if (bus.oP0_ReadyRd !== 1'b1 || bus.oP1_ReadyRd !== 1'b0 || bus.oMAC_ValidRd !== 1'b0) begin
            miscompares++;
            $display("FAIL single_grant: got r0 %b r1 %b v %b want 1 0 0",
                     bus.oP0_ReadyRd, bus.oP1_ReadyRd, bus.oMAC_ValidRd);
        end
        tick();
        bus.iP0_ValidRd = 0;
        #1;
        vectors++;
        if (bus.oMAC_ValidRd !== 1'b1 || bus.oMAC_TagRd !== 4'b0101 ||
            bus.oMAC_AddrRd !== 32'h2325_F220 || bus.oMAC_IdRd !== 3'b101 ||
            bus.oMAC_LenRd !== 2'b10 || bus.oMAC_QoSRd !== 4'b0110) begin
            miscompares++;
            $display("FAIL single_issue: got v %b tag %b addr %h id %b len %b qos %b",
                     bus.oMAC_ValidRd, bus.oMAC_TagRd, bus.oMAC_AddrRd, bus.oMAC_IdRd,
                     bus.oMAC_LenRd, bus.oMAC_QoSRd);
        end
        tick();
        vectors++;
        if (bus.oMAC_ValidRd !== 1'b0) begin
            miscompares++; $display("FAIL single_one_cycle: got v %b want 0", bus.oMAC_ValidRd);
        end
        bus.iMAC_ValidRsp = 1; bus.iMAC_TagRsp = 4'b0101; bus.iMAC_DataRsp = 32'hA5A5_0001;
        bus.iMAC_StatusRsp = 2'b01; bus.iMAC_EoD = 0; bus.iP0_ReadyRsp = 1;
        #1;
        vectors++;
        if (bus.oP0_ValidRsp !== 1'b1 || bus.oP1_ValidRsp !== 1'b0 || bus.oP0_IdRsp !== 3'b101 ||
            bus.oP0_DataRsp !== 32'hA5A5_0001 || bus.oMAC_ReadyRsp !== 1'b1) begin
            miscompares++;
            $display("FAIL single_beat1: got v0 %b v1 %b id %b data %h rdy %b",
                     bus.oP0_ValidRsp, bus.oP1_ValidRsp, bus.oP0_IdRsp, bus.oP0_DataRsp,
                     bus.oMAC_ReadyRsp);
        end
        tick();
        bus.iMAC_DataRsp = 32'hA5A5_0002; bus.iMAC_StatusRsp = 2'b10; bus.iMAC_EoD = 1;
        #1;
        vectors++;
        if (bus.oP0_EoD !== 1'b1 || bus.oP1_DataRsp !== 32'hA5A5_0002 ||
            bus.oP0_StatusRsp !== 2'b10) begin
            miscompares++;
            $display("FAIL single_beat2: got eod %b data1 %h st %b want 1 a5a50002 10",
                     bus.oP0_EoD, bus.oP1_DataRsp, bus.oP0_StatusRsp);
        end
        tick();
        bus.iMAC_ValidRsp = 0; bus.iMAC_EoD = 0;
        #1;
        vectors++;
        if (bus.oErrUnexp !== 1'b0) begin
            miscompares++; $display("FAIL single_no_err: got %b want 0", bus.oErrUnexp);
        end
        // A further EoD proves the count went back to zero.
        bus.iMAC_ValidRsp = 1; bus.iMAC_EoD = 1;
        tick();
        bus.iMAC_ValidRsp = 0; bus.iMAC_EoD = 0;
        #1;
        vectors++;
        if (bus.oErrUnexp !== 1'b1) begin
            miscompares++; $display("FAIL single_outst_zero: got err %b want 1", bus.oErrUnexp);
        end
    endtask

    task automatic test_qos();
        do_reset();
        bus.iMAC_ReadyRd = 1;
        bus.iP0_ValidRd = 1; bus.iP0_QoSRd = 4'd2; bus.iP0_IdRd = 3'd1; bus.iP0_AddrRd = 32'h100;
        bus.iP1_ValidRd = 1; bus.iP1_QoSRd = 4'd9; bus.iP1_IdRd = 3'd2; bus.iP1_AddrRd = 32'h200;
        #1;
        vectors++;
        if (bus.oP1_ReadyRd !== 1'b1 || bus.oP0_ReadyRd !== 1'b0) begin
            miscompares++;
            $display("FAIL qos_first: got r0 %b r1 %b want 0 1", bus.oP0_ReadyRd, bus.oP1_ReadyRd);
        end
        tick();
        bus.iP1_ValidRd = 0;
        #1;
        vectors++;
        if (bus.oMAC_TagRd !== 4'b1010 || bus.oMAC_AddrRd !== 32'h200 ||
            bus.oP0_ReadyRd !== 1'b1) begin
            miscompares++;
            $display("FAIL qos_second: got tag %b addr %h r0 %b want 1010 200 1",
                     bus.oMAC_TagRd, bus.oMAC_AddrRd, bus.oP0_ReadyRd);
        end
        tick();
        bus.iP0_ValidRd = 0;
        #1;
        vectors++;
        if (bus.oMAC_TagRd !== 4'b0001 || bus.oMAC_ValidRd !== 1'b1) begin
            miscompares++;
            $display("FAIL qos_p0_issue: got tag %b v %b want 0001 1",
                     bus.oMAC_TagRd, bus.oMAC_ValidRd);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.iMAC_ReadyRd = 1;
        bus.iP0_ValidRd = 1; bus.iP0_QoSRd = 4'd5;
        bus.iP1_ValidRd = 1; bus.iP1_QoSRd = 4'd5;
        for (int i = 0; i < 6; i++) begin
            #1;
            vectors++;
            if (bus.oP0_ReadyRd !== ((i % 2) == 0) || bus.oP1_ReadyRd !== ((i % 2) == 1)) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got r0 %b r1 %b want port %0d",
                         i, bus.oP0_ReadyRd, bus.oP1_ReadyRd, i % 2);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_starvation();
        logic prevPort;
        logic [7:0] expPorts;
        expPorts = 8'b0111_0111;  // bit i = 1 -> P1 expected on grant i
        do_reset();
        bus.iMAC_ReadyRd = 1;
        bus.iP0_ValidRd = 1; bus.iP0_QoSRd = 4'd0;
        bus.iP1_ValidRd = 1; bus.iP1_QoSRd = 4'd15;
        bus.iP0_ReadyRsp = 1; bus.iP1_ReadyRsp = 1;
        prevPort = 1'b0;
        for (int i = 0; i < 8; i++) begin
            // Retire the previous grant so the outstanding limit never interferes.
            bus.iMAC_ValidRsp = (i != 0); bus.iMAC_EoD = (i != 0);
            bus.iMAC_TagRsp = {prevPort, 3'b000};
            #1;
            vectors++;
            if (bus.oP1_ReadyRd !== expPorts[i] || bus.oP0_ReadyRd !== !expPorts[i]) begin
                miscompares++;
                $display("FAIL age_grant%0d: got r0 %b r1 %b want port %0d",
                         i, bus.oP0_ReadyRd, bus.oP1_ReadyRd, expPorts[i]);
            end
            prevPort = expPorts[i];
            tick();
        end
        bus.iP0_ValidRd = 0; bus.iP1_ValidRd = 0;
        bus.iMAC_ValidRsp = 1; bus.iMAC_EoD = 1; bus.iMAC_TagRsp = {prevPort, 3'b000};
        tick();
        idle();
        #1;
        vectors++;
        if (bus.oErrUnexp !== 1'b0) begin
            miscompares++; $display("FAIL age_no_err: got %b want 0", bus.oErrUnexp);
        end
    endtask

    task automatic test_outstanding();
        do_reset();
        bus.iMAC_ReadyRd = 1;
        bus.iP0_ValidRd = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (bus.oP0_ReadyRd !== 1'b1) begin
                miscompares++; $display("FAIL outst_accept%0d: got %b want 1", i, bus.oP0_ReadyRd);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (bus.oP0_ReadyRd !== 1'b0) begin
                miscompares++; $display("FAIL outst_block%0d: got %b want 0", i, bus.oP0_ReadyRd);
            end
            tick();
        end
        bus.iMAC_ValidRsp = 1; bus.iMAC_TagRsp = 4'b0000; bus.iMAC_EoD = 1; bus.iP0_ReadyRsp = 1;
        #1;
        vectors++;
        if (bus.oP0_ReadyRd !== 1'b0) begin
            miscompares++; $display("FAIL outst_eod_cycle: got %b want 0", bus.oP0_ReadyRd);
        end
        tick();
        bus.iMAC_ValidRsp = 0; bus.iMAC_EoD = 0;
        #1;
        vectors++;
        if (bus.oP0_ReadyRd !== 1'b1) begin
            miscompares++; $display("FAIL outst_reassert: got %b want 1", bus.oP0_ReadyRd);
        end
        tick();
        idle();
    endtask

    task automatic test_hold();
        do_reset();
        bus.iP0_ValidRd = 1; bus.iP0_AddrRd = 32'hCAFE_0010; bus.iP0_IdRd = 3'd3;
        bus.iP0_LenRd = 2'd1; bus.iP0_QoSRd = 4'd4;
        #1;
        vectors++;
        if (bus.oP0_ReadyRd !== 1'b1) begin
            miscompares++; $display("FAIL hold_load: got %b want 1", bus.oP0_ReadyRd);
        end
        tick();
        bus.iP0_AddrRd = 32'hBEEF_0020; bus.iP0_IdRd = 3'd6; bus.iP0_LenRd = 2'd3;
        bus.iP0_QoSRd = 4'd7;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (bus.oMAC_ValidRd !== 1'b1 || bus.oMAC_AddrRd !== 32'hCAFE_0010 ||
                bus.oMAC_TagRd !== 4'b0011 || bus.oMAC_LenRd !== 2'd1 ||
                bus.oMAC_QoSRd !== 4'd4 || bus.oP0_ReadyRd !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_stable%0d: got v %b addr %h tag %b len %b qos %h r0 %b",
                         i, bus.oMAC_ValidRd, bus.oMAC_AddrRd, bus.oMAC_TagRd,
                         bus.oMAC_LenRd, bus.oMAC_QoSRd, bus.oP0_ReadyRd);
            end
            tick();
        end
        bus.iMAC_ReadyRd = 1;
        #1;
        vectors++;
        if (bus.oP0_ReadyRd !== 1'b1) begin
            miscompares++; $display("FAIL hold_release: got %b want 1", bus.oP0_ReadyRd);
        end
        tick();
        bus.iP0_ValidRd = 0;
        #1;
        vectors++;
        if (bus.oMAC_AddrRd !== 32'hBEEF_0020 || bus.oMAC_TagRd !== 4'b0110) begin
            miscompares++;
            $display("FAIL hold_next: got addr %h tag %b want beef0020 0110",
                     bus.oMAC_AddrRd, bus.oMAC_TagRd);
        end
        tick();
        idle();
    endtask

    task automatic test_rsp_routing();
        do_reset();
        bus.iMAC_ReadyRd = 1;
        bus.iP1_ValidRd = 1; bus.iP1_IdRd = 3'd3;
        tick();
        idle();
        bus.iMAC_ValidRsp = 1; bus.iMAC_TagRsp = 4'b1011; bus.iMAC_EoD = 1;
        bus.iP0_ReadyRsp = 1; bus.iP1_ReadyRsp = 0;
        #1;
        vectors++;
        if (bus.oMAC_ReadyRsp !== 1'b0 || bus.oP0_ValidRsp !== 1'b0 ||
            bus.oP1_ValidRsp !== 1'b1 || bus.oP1_IdRsp !== 3'b011) begin
            miscompares++;
            $display("FAIL route_stall: got rdy %b v0 %b v1 %b id %b want 0 0 1 011",
                     bus.oMAC_ReadyRsp, bus.oP0_ValidRsp, bus.oP1_ValidRsp, bus.oP1_IdRsp);
        end
        tick();
        bus.iP1_ReadyRsp = 1;
        #1;
        vectors++;
        if (bus.oMAC_ReadyRsp !== 1'b1) begin
            miscompares++; $display("FAIL route_release: got %b want 1", bus.oMAC_ReadyRsp);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (bus.oErrUnexp !== 1'b0) begin
            miscompares++; $display("FAIL route_single_completion: got err %b want 0", bus.oErrUnexp);
        end
    endtask

    task automatic test_unexpected_and_reset();
        do_reset();
        bus.iMAC_ValidRsp = 1; bus.iMAC_TagRsp = 4'b0000; bus.iMAC_EoD = 1; bus.iP0_ReadyRsp = 1;
        tick();
        idle();
        #1;
        vectors++;
        if (bus.oErrUnexp !== 1'b1) begin
            miscompares++; $display("FAIL unexp_set: got %b want 1", bus.oErrUnexp);
        end
        // A wrapped counter would block P0 at once; a held zero allows four accepts.
        bus.iMAC_ReadyRd = 1; bus.iP0_ValidRd = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (bus.oP0_ReadyRd !== 1'b1) begin
                miscompares++; $display("FAIL unexp_no_wrap%0d: got %b want 1", i, bus.oP0_ReadyRd);
            end
            tick();
        end
        #1;
        vectors++;
        if (bus.oP0_ReadyRd !== 1'b0 || bus.oErrUnexp !== 1'b1) begin
            miscompares++;
            $display("FAIL unexp_limit: got r0 %b err %b want 0 1", bus.oP0_ReadyRd, bus.oErrUnexp);
        end
        bus.iP0_ValidRd = 0;
        tick();
        bus.iMAC_ReadyRd = 0; bus.iP1_ValidRd = 1; bus.iP1_IdRd = 3'd7;
        tick();
        bus.iP1_ValidRd = 0;
        #1;
        vectors++;
        if (bus.oMAC_ValidRd !== 1'b1 || bus.oMAC_TagRd !== 4'b1111) begin
            miscompares++;
            $display("FAIL rst_pending: got v %b tag %b want 1 1111", bus.oMAC_ValidRd, bus.oMAC_TagRd);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.oMAC_ValidRd !== 1'b0 || bus.oErrUnexp !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: got v %b err %b want 0 0", bus.oMAC_ValidRd, bus.oErrUnexp);
        end
        bus.iP0_ValidRd = 1;
        #1;
        vectors++;
        if (bus.oP0_ReadyRd !== 1'b1) begin
            miscompares++; $display("FAIL rst_outst_clear: got %b want 1", bus.oP0_ReadyRd);
        end
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_single();
        test_qos();
        test_round_robin();
        test_starvation();
        test_outstanding();
        test_hold();
        test_rsp_routing();
        test_unexpected_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
